// File: rtl/pc_pkg.sv
// Processor-wide constants shared by the fetch stage: address width and reset vector.
package pc_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pc_if.sv
// Next-PC / current-PC signal bundle between the next-PC logic and the PC register.
interface pc_if
    import pc_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic [WIDTH-1:0] pcp;
    logic [WIDTH-1:0] pc_out;

    modport master (output pcp, input pc_out);
    modport slave  (input pcp, output pc_out);
endinterface

// File: rtl/pc.sv
// Program counter register: captures the next-PC value on every rising edge.
module pc
    import pc_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VECTOR)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PCP,
    output logic [WIDTH-1:0] PCOut
);
    // Declaration initialiser keeps PCOut defined even if RST is never asserted.
    logic [WIDTH-1:0] pc_reg = RESET_VALUE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_reg <= RESET_VALUE;
        end else begin
            pc_reg <= PCP;
        end
    end

    assign PCOut = pc_reg;
endmodule

// File: tb/tb_pc.sv
// Directed bench for the PC register: 32-bit default instance and a 16-bit override.
module tb_pc;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        rst16 = 1'b0;
    int          checks = 0;
    int          errors = 0;

    pc_if #(.WIDTH(32)) bus ();
    pc_if #(.WIDTH(16)) bus16 ();

    pc dut (
        .CLK   (CLK),
        .RST   (RST),
        .PCP   (bus.pcp),
        .PCOut (bus.pc_out)
    );

    pc #(.WIDTH(16), .RESET_VALUE(16'h0100)) dut16 (
        .CLK   (CLK),
        .RST   (rst16),
        .PCP   (bus16.pcp),
        .PCOut (bus16.pc_out)
    );

    always #10 CLK = ~CLK;

    // Model: what was present on the inputs at the latest edge decides the PC.
    logic [31:0] edge_pcp[$];
    logic        edge_rst[$];
    logic [31:0] model32 = 32'h0000_0000;
    logic [15:0] model16 = 16'h0100;

    always @(posedge CLK) begin
        edge_pcp.push_back(bus.pcp);
        edge_rst.push_back(RST);
        model32 <= RST ? 32'h0000_0000 : bus.pcp;
        model16 <= rst16 ? 16'h0100 : bus16.pcp;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare just after each edge and just before the next one (output must hold).
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            check32("model32_post", bus.pc_out, model32);
            check16("model16_post", bus16.pc_out, model16);
            #17;
            check32("model32_hold", bus.pc_out, model32);
            check16("model16_hold", bus16.pc_out, model16);
        end
    end

    task automatic apply(input logic rst_v, input logic [31:0] pcp_v);
        @(negedge CLK);
        RST     = rst_v;
        bus.pcp = pcp_v;
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        bus.pcp   = 32'h0;
        bus16.pcp = 16'h0;
        #1;
        checks++;
        if ($isunknown(bus.pc_out)) begin
            errors++;
            $display("FAIL powerup_x: got %h expected 00000000", bus.pc_out);
        end
        check32("powerup_pre_edge", bus.pc_out, 32'h0);
        after_edge();
        check32("powerup_first_edge", bus.pc_out, 32'h0);
        $display("txn powerup pc=%h", bus.pc_out);

        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 32'(i));
            after_edge();
            check32("seq_load", bus.pc_out, 32'(i));
            $display("txn seq pcp=%h pc=%h", 32'(i), bus.pc_out);
        end

        @(negedge CLK);
        bus.pcp = 32'h10;
        #3 bus.pcp = 32'h20;
        #3 bus.pcp = 32'h30;
        #1 check32("midcycle_no_effect", bus.pc_out, 32'h5);
        after_edge();
        check32("midcycle_last", bus.pc_out, 32'h30);
        $display("txn midcycle pc=%h", bus.pc_out);

        apply(1'b0, 32'h5);
        after_edge();
        check32("pre_reset", bus.pc_out, 32'h5);
        apply(1'b1, 32'hABCD_0000);
        #1 check32("reset_before_edge", bus.pc_out, 32'h5);
        for (int i = 0; i < 4; i++) begin
            after_edge();
            check32("reset_held", bus.pc_out, 32'h0);
            $display("txn reset cycle=%0d pc=%h", i, bus.pc_out);
        end
        apply(1'b0, 32'hABCD_0000);
        after_edge();
        check32("reset_release", bus.pc_out, 32'hABCD_0000);
        $display("txn release pc=%h", bus.pc_out);

        apply(1'b0, 32'hFFFF_FFFF);
        after_edge();
        check32("extreme_ones", bus.pc_out, 32'hFFFF_FFFF);
        apply(1'b0, 32'h0000_0001);
        after_edge();
        check32("extreme_odd", bus.pc_out, 32'h0000_0001);
        apply(1'b0, 32'h8000_0000);
        after_edge();
        check32("extreme_msb", bus.pc_out, 32'h8000_0000);
        $display("txn extremes pc=%h", bus.pc_out);

        @(negedge CLK);
        rst16     = 1'b1;
        bus16.pcp = 16'h1234;
        after_edge();
        check16("w16_reset", bus16.pc_out, 16'h0100);
        @(negedge CLK);
        rst16     = 1'b0;
        bus16.pcp = 16'hFFFE;
        after_edge();
        check16("w16_load", bus16.pc_out, 16'hFFFE);
        $display("txn w16 pc=%h", bus16.pc_out);

        checks++;
        if (edge_pcp.size() != edge_rst.size() || edge_pcp.size() == 0) begin
            errors++;
            $display("FAIL edge_log: got %0d expected %0d", edge_pcp.size(), edge_rst.size());
        end

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pc.md
# pc

Program counter register for the single-cycle processor datapath. Holds the address of the instruction currently being fetched and loads the next-PC value (computed externally by the PC-select/adder logic) on every rising clock edge. Sits between the next-PC mux and the instruction memory address input.

## Interface

Parameters:
- WIDTH, 32: address width in bits.
- RESET_VALUE, 32'h0000_0000: value loaded on reset and at power-up/initialisation.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, synchronous and active-high.
- PCP  input  WIDTH  next PC value (PC-prime), from the next-PC logic.
- PCOut  output  WIDTH  current PC, registered; drives instruction memory address and the PC+4 adder.

## Operation

- Single WIDTH-bit register; PCOut is the register output directly, with no combinational path from PCP to PCOut.
- Rising CLK edge with RST=1: register <= RESET_VALUE.
- Rising CLK edge with RST=0: register <= PCP, unconditionally. No enable, stall, or hold input; the PC advances every cycle.
- RST has priority over the PCP load.
- No arithmetic inside the block: no increment, alignment masking, or range check. PCP is captured bit-for-bit, including odd and unaligned values such as 32'h0000_0001, and all-ones.
- Register is initialised to RESET_VALUE at time zero, through a declaration initialiser honoured by simulation and FPGA synthesis. PCOut is therefore never X, even if RST is never asserted.
- Asserting RST mid-run discards the in-flight PCP. Loading resumes on the first edge after RST returns low.

## Timing

- Latency: 1 cycle. A PCP value present at rising edge N appears on PCOut immediately after edge N and is held until edge N+1.
- PCP changes between edges have no effect on PCOut.
- Reset: PCOut = RESET_VALUE after the first rising edge with RST high. It stays at RESET_VALUE on every edge while RST is held.
- First edge after RST deasserts: PCOut = PCP sampled at that edge.
- Setup/hold: PCP and RST must be stable around the rising edge. The bench changes stimulus mid-period, away from edges.

## Structure

- No shared package is required. WIDTH and RESET_VALUE are module parameters.
- If a processor-wide package exists, it holds the XLEN/address-width constant and the reset vector, and the instantiating module passes them in.
- No sub-modules: one always block plus the output assignment.

## Test plan

- Power-up, no reset: CLK period 20 ns, RST=0, PCP=32'h0. Before the first edge PCOut=32'h0 (initial value), not X. After the first edge PCOut=32'h0.
- Sequential load: apply PCP=1,2,3,4,5, each held for one full period and changed mid-period. After each rising edge PCOut equals the PCP value present at that edge (1,2,3,4,5), and it is stable between edges.
- Mid-cycle change: PCP 32'h10 -> 32'h20 -> 32'h30 between two edges. PCOut takes only 32'h30 at the next edge.
- Synchronous reset: PCOut=32'h5, then raise RST with PCP=32'hABCD_0000. PCOut is unchanged until the edge, then becomes 32'h0 and stays 32'h0 for 3 held cycles. After RST falls, the next edge loads 32'hABCD_0000.
- Extremes: PCP=32'hFFFF_FFFF, then 32'h0000_0001, then 32'h8000_0000. PCOut captures each exactly, with no masking or wrap logic.
- Parameter override: WIDTH=16, RESET_VALUE=16'h0100. Reset gives PCOut=16'h0100, and PCP=16'hFFFE loads to 16'hFFFE.
